// File: rtl/hcsr04_scan_scheduler.sv
// Round-robin scheduler for up to eight HC-SR04 ultrasonic sensors.
// Only one sensor is fired at a time. Each echo pulse is timed, converted to
// millimetres and stored in that sensor's distance register.
module hcsr04_scan_scheduler #(
    parameter int N_SENSORS      = 4,
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 4194303,
    parameter int GUARD_CYCLES   = 500000
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      enable,
    input  logic [N_SENSORS-1:0]      sensor_mask,
    input  logic [N_SENSORS-1:0]      echo_in,
    output logic [N_SENSORS-1:0]      trigger_out,
    output logic [12*N_SENSORS-1:0]   distance_flat,
    output logic                      sample_valid,
    output logic [2:0]                sample_idx,
    output logic                      sample_timeout,
    output logic                      busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TRIG  = 3'd1,
        S_WAIT  = 3'd2,
        S_MEAS  = 3'd3,
        S_DONE  = 3'd4,
        S_GUARD = 3'd5
    } state_t;

    localparam logic [21:0] TRIG_LAST  = 22'(TRIG_CYCLES - 1);
    localparam logic [21:0] GUARD_LAST = 22'(GUARD_CYCLES - 1);
    localparam logic [21:0] TO_LAST    = 22'(TIMEOUT_CYCLES - 1);
    localparam logic [22:0] TO_LAST23  = 23'(TIMEOUT_CYCLES - 1);

    state_t                         r_state, w_next;
    logic [21:0]                    r_cnt;
    logic [21:0]                    r_wait_cnt;
    logic [2:0]                     r_cur_idx;
    logic                           r_started;
    logic [11:0]                    r_dist;
    logic                           r_to;
    logic [N_SENSORS-1:0]           r_echo_s1, r_echo_s2, r_echo_d;
    logic [N_SENSORS-1:0][11:0]     r_dist_q;
    logic                           r_valid;
    logic [2:0]                     r_idx;
    logic                           r_to_out;

    logic [7:0]                     w_mask8, w_s2_8, w_d8;
    logic                           w_rise, w_fall;
    logic [22:0]                    w_elapsed;
    logic                           w_meas_to;
    logic [2:0]                     w_base;
    logic [3:0]                     w_j;
    logic                           w_sel_found;
    logic [2:0]                     w_sel_idx;
    logic                           w_go;
    logic [31:0]                    w_prod;
    logic [13:0]                    w_dist14;
    logic [11:0]                    w_dist;

    // Pad per-sensor vectors to 8 bits so a 3-bit index is always in range.
    assign w_mask8 = 8'(sensor_mask);
    assign w_s2_8  = 8'(r_echo_s2);
    assign w_d8    = 8'(r_echo_d);

    // Edges of the selected sensor's synchronised echo. The edge flop tracks
    // the echo continuously, so an echo already high on WAIT entry never
    // shows a rise, and anything seen during TRIG is simply not looked at.
    assign w_rise = w_s2_8[r_cur_idx] & ~w_d8[r_cur_idx];
    assign w_fall = ~w_s2_8[r_cur_idx] & w_d8[r_cur_idx];

    // Total time since the trigger ended: saved WAIT time plus running MEAS time.
    assign w_elapsed = {1'b0, r_wait_cnt} + {1'b0, r_cnt};
    assign w_meas_to = (w_elapsed >= TO_LAST23);

    // Width-to-millimetre conversion: width * 891 / 2^18, saturating at 4095.
    assign w_prod   = {10'd0, r_cnt} * 32'd891;
    assign w_dist14 = w_prod[31:18];
    assign w_dist   = (|w_dist14[13:12]) ? 12'hFFF : w_dist14[11:0];

    // Scan can (re)start only with enable high and at least one sensor in the mask.
    assign w_go = enable & (|sensor_mask);

    // After reset the search starts just before sensor 0, so sensor 0 is tried first.
    assign w_base = r_started ? r_cur_idx : 3'(N_SENSORS - 1);

    // Next sensor: first mask bit strictly after the base, wrapping modulo N.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = 3'd0;
        w_j         = 4'd0;
        for (int k = 1; k <= N_SENSORS; k++) begin
            w_j = 4'((int'(w_base) + k) % N_SENSORS);
            if (!w_sel_found && w_mask8[w_j[2:0]]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_j[2:0];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_go) w_next = S_TRIG;
            S_TRIG:  if (r_cnt == TRIG_LAST) w_next = S_WAIT;
            S_WAIT:  begin
                if (w_rise)                w_next = S_MEAS;
                else if (r_cnt == TO_LAST) w_next = S_DONE;
            end
            S_MEAS:  if (w_fall || w_meas_to) w_next = S_DONE;
            S_DONE:  w_next = S_GUARD;
            S_GUARD: if (r_cnt == GUARD_LAST) w_next = w_go ? S_TRIG : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Shared counter, cleared on every state change; WAIT time saved for MEAS.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt      <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_cnt <= (w_next != r_state) ? 22'd0 : r_cnt + 22'd1;
            if (r_state == S_WAIT && w_next == S_MEAS) r_wait_cnt <= r_cnt;
        end
    end

    // Sensor selection, made only when leaving IDLE or GUARD for TRIG.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cur_idx <= '0;
            r_started <= 1'b0;
        end else if ((r_state == S_IDLE || r_state == S_GUARD) && w_next == S_TRIG) begin
            r_cur_idx <= w_sel_idx;
            r_started <= 1'b1;
        end
    end

    // Echo synchroniser (two flops) followed by the edge-detect flop.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_echo_s1 <= '0;
            r_echo_s2 <= '0;
            r_echo_d  <= '0;
        end else begin
            r_echo_s1 <= echo_in;
            r_echo_s2 <= r_echo_s1;
            r_echo_d  <= r_echo_s2;
        end
    end

    // Capture the finished sample's distance and timeout flag on the way to DONE.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_dist <= 12'hFFF;
            r_to   <= 1'b0;
        end else if (w_next == S_DONE) begin
            if (r_state == S_MEAS && w_fall) begin
                r_dist <= w_dist;
                r_to   <= 1'b0;
            end else begin
                r_dist <= 12'hFFF;
                r_to   <= 1'b1;
            end
        end
    end

    // DONE writes the distance register and raises the one-cycle sample strobe.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_dist_q <= {N_SENSORS{12'hFFF}};
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_to_out <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (r_state == S_DONE) begin
                r_valid  <= 1'b1;
                r_idx    <= r_cur_idx;
                r_to_out <= r_to;
                for (int k = 0; k < N_SENSORS; k++)
                    if (r_cur_idx == 3'(k)) r_dist_q[k] <= r_dist;
            end
        end
    end

    // Trigger decoded from state so an async reset drops it immediately.
    always_comb begin
        trigger_out = '0;
        if (r_state == S_TRIG)
            for (int k = 0; k < N_SENSORS; k++)
                if (r_cur_idx == 3'(k)) trigger_out[k] = 1'b1;
    end

    assign distance_flat  = r_dist_q;
    assign sample_valid   = r_valid;
    assign sample_idx     = r_idx;
    assign sample_timeout = r_to_out;
    assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_hcsr04_scan_scheduler.sv
// Directed bench for hcsr04_scan_scheduler (N=4, TRIG=4, TIMEOUT=20000, GUARD=10).
module tb_hcsr04_scan_scheduler;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        enable;
    logic [3:0]  sensor_mask;
    logic [3:0]  echo_in;
    logic [3:0]  trigger_out;
    logic [47:0] distance_flat;
    logic        sample_valid;
    logic [2:0]  sample_idx;
    logic        sample_timeout;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hcsr04_scan_scheduler #(
        .N_SENSORS      (4),
        .TRIG_CYCLES    (4),
        .TIMEOUT_CYCLES (20000),
        .GUARD_CYCLES   (10)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .enable         (enable),
        .sensor_mask    (sensor_mask),
        .echo_in        (echo_in),
        .trigger_out    (trigger_out),
        .distance_flat  (distance_flat),
        .sample_valid   (sample_valid),
        .sample_idx     (sample_idx),
        .sample_timeout (sample_timeout),
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for any trigger, check it is sensor k, and return its high time.
    task automatic wait_trig(input int k, output int hi);
        int t;
        logic [3:0] exp;
        exp = 4'(1 << k);
        t = 0;
        while (trigger_out === 4'b0000 && t < 40000) begin tick(); t++; end
        chk($sformatf("trig_sel_%0d", k), 64'(trigger_out), 64'(exp));
        hi = 0;
        while (trigger_out === exp && hi < 100) begin tick(); hi++; end
    endtask

    // Drive an echo of w cycles on sensor k after dly cycles; return cycles
    // from the falling pin to sample_valid.
    task automatic pulse(input int k, input int dly, input int w, output int lat);
        repeat (dly) tick();
        echo_in[k] = 1'b1;
        repeat (w) tick();
        echo_in[k] = 1'b0;
        lat = 0;
        while (sample_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
    endtask

    task automatic wait_valid(input int bound, output int cyc);
        cyc = 0;
        while (sample_valid !== 1'b1 && cyc < bound) begin tick(); cyc++; end
    endtask

    initial begin
        int hi, lat, cyc, c;
        bit seen;

        n_rst       = 1'b0;
        enable      = 1'b0;
        sensor_mask = 4'b0000;
        echo_in     = 4'b0000;
        repeat (3) tick();
        chk("rst_trig",  64'(trigger_out), 64'h0);
        chk("rst_dist",  64'(distance_flat), 64'hFFF_FFF_FFF_FFF);
        chk("rst_valid", 64'(sample_valid), 64'h0);
        chk("rst_busy",  64'(busy), 64'h0);
        chk("rst_idx",   64'(sample_idx), 64'h0);
        chk("rst_to",    64'(sample_timeout), 64'h0);
        n_rst = 1'b1;
        repeat (3) tick();
        chk("idle_busy", 64'(busy), 64'h0);

        // Alternating scan over sensors 0 and 2.
        sensor_mask = 4'b0101;
        enable      = 1'b1;
        wait_trig(0, hi);
        chk("t1_trig_w0", 64'(hi), 64'd4);
        pulse(0, 20, 4000, lat);
        chk("t1_lat", 64'(lat), 64'd4);
        chk("t1_idx0", 64'(sample_idx), 64'd0);
        chk("t1_to0", 64'(sample_timeout), 64'd0);
        chk("t1_dist0", 64'(distance_flat[11:0]), 64'd13);
        tick();
        chk("t1_valid_pulse", 64'(sample_valid), 64'd0);
        wait_trig(2, hi);
        chk("t1_trig_w2", 64'(hi), 64'd4);
        pulse(2, 20, 1000, lat);
        chk("t1_idx2", 64'(sample_idx), 64'd2);
        chk("t1_dist2", 64'(distance_flat[35:24]), 64'd3);
        wait_trig(0, hi);
        pulse(0, 20, 8000, lat);
        chk("t1_dist0b", 64'(distance_flat[11:0]), 64'd27);
        sensor_mask = 4'b0010;

        // Single sensor 1: good sample, then no echo, then good again.
        wait_trig(1, hi);
        pulse(1, 20, 2000, lat);
        chk("t2_dist1", 64'(distance_flat[23:12]), 64'd6);
        wait_trig(1, hi);
        wait_valid(25000, cyc);
        chk("t2_to_valid", 64'(sample_valid), 64'd1);
        chk("t2_to_flag", 64'(sample_timeout), 64'd1);
        chk("t2_to_idx", 64'(sample_idx), 64'd1);
        chk("t2_to_dist", 64'(distance_flat[23:12]), 64'hFFF);
        chk("t2_to_time", 64'(cyc >= 19995 && cyc <= 20005), 64'd1);
        wait_trig(1, hi);
        pulse(1, 20, 2000, lat);
        chk("t2_dist1b", 64'(distance_flat[23:12]), 64'd6);
        chk("t2_to_clr", 64'(sample_timeout), 64'd0);

        // Echo held beyond the timeout.
        wait_trig(1, hi);
        repeat (100) tick();
        echo_in[1] = 1'b1;
        wait_valid(25000, cyc);
        echo_in[1] = 1'b0;
        chk("t4_valid", 64'(sample_valid), 64'd1);
        chk("t4_to", 64'(sample_timeout), 64'd1);
        chk("t4_dist", 64'(distance_flat[23:12]), 64'hFFF);

        // Drop enable mid-measurement: sample still lands, then scan stops.
        wait_trig(1, hi);
        repeat (30) tick();
        echo_in[1] = 1'b1;
        repeat (500) tick();
        enable = 1'b0;
        repeat (1000) tick();
        echo_in[1] = 1'b0;
        lat = 0;
        while (sample_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
        chk("t5_valid", 64'(sample_valid), 64'd1);
        chk("t5_dist", 64'(distance_flat[23:12]), 64'd5);
        chk("t5_to", 64'(sample_timeout), 64'd0);
        c = 0;
        while (busy !== 1'b0 && c < 40) begin tick(); c++; end
        chk("t5_guard_len", 64'(c), 64'd10);
        seen = 1'b0;
        repeat (50) begin
            tick();
            if (trigger_out !== 4'b0000) seen = 1'b1;
        end
        chk("t5_no_trig", 64'(seen), 64'd0);
        chk("t5_idle", 64'(busy), 64'd0);

        // Reset during TRIG of sensor 3; scan restarts at sensor 0.
        sensor_mask = 4'b1001;
        enable      = 1'b1;
        c = 0;
        while (trigger_out === 4'b0000 && c < 100) begin tick(); c++; end
        chk("t6_trig3", 64'(trigger_out), 64'h8);
        tick();
        #2;
        n_rst = 1'b0;
        #1;
        chk("t6_trig_drop", 64'(trigger_out), 64'h0);
        chk("t6_busy", 64'(busy), 64'h0);
        chk("t6_dist", 64'(distance_flat), 64'hFFF_FFF_FFF_FFF);
        repeat (2) tick();
        #2;
        n_rst = 1'b1;
        wait_trig(0, hi);
        chk("t6_trig_w0", 64'(hi), 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
